// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the multiply/divide sequencer.
// Holds op/state enums, the divide-by-zero quotient value and counter width.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    localparam logic [31:0] DIV_BY_ZERO_LO = 32'hFFFF_FFFF;
    localparam int CNT_W = $clog2(32);

    // Two's-complement magnitude when the operand is signed and negative.
    function automatic logic [31:0] mag32(input logic [31:0] x,
                                          input logic sgn);
        return (sgn && x[31]) ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/div_core.sv
// div_core: restoring iterative unsigned divider, one quotient bit per cycle.
// Ports: clk_i, rst_i (async active-low), start, dividend, divisor, abort,
//        quotient, remainder, last_iter (high during the final iteration).
module div_core
    import muldiv_pkg::*;
#(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        abort,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        last_iter
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_ITERS - 1);

    logic             active;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      dsor;
    logic [32:0]      shifted;
    logic [32:0]      diff;

    // Partial remainder shifted left with the next dividend bit appended.
    assign shifted   = {remainder, quotient[31]};
    assign diff      = shifted - {1'b0, dsor};
    assign last_iter = active && (cnt == LAST);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            active    <= 1'b0;
            cnt       <= '0;
            dsor      <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (abort) begin
            active <= 1'b0;
        end else if (start) begin
            active    <= 1'b1;
            cnt       <= '0;
            dsor      <= divisor;
            quotient  <= dividend;
            remainder <= '0;
        end else if (active) begin
            // diff[32] set means the trial subtract went negative: restore.
            if (!diff[32]) begin
                remainder <= diff[31:0];
                quotient  <= {quotient[30:0], 1'b1};
            end else begin
                remainder <= shifted[31:0];
                quotient  <= {quotient[30:0], 1'b0};
            end
            cnt <= cnt + CNT_W'(1);
            if (last_iter) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX stage.
// Ports: clk_i, rst_i (async active-low), start_i, op_i, a_i, b_i, flush_i,
//        stall_o, busy_o, done_o (1-cycle pulse), hi_o, lo_o.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int MUL_LATENCY = 2,
    parameter int DIV_ITERS   = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  md_op_e      op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LATENCY - 1);

    md_state_e        state;
    md_state_e        state_nx;
    logic [CNT_W-1:0] cnt;

    logic        is_mul_q;
    logic        neg_q;
    logic        neg_r;
    logic        dz_q;
    logic [31:0] a_raw;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] held_hi;
    logic [31:0] held_lo;
    logic [63:0] pipe [MUL_LATENCY];

    logic        accept;
    logic        in_sgn;
    logic        in_div;
    logic        b_zero;
    logic        div_start;
    logic        div_abort;
    logic        last_iter;
    logic [31:0] in_mag_a;
    logic [31:0] in_mag_b;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [63:0] prod;
    logic [63:0] fin;

    assign accept    = (state == ST_IDLE) && start_i && !flush_i;
    assign in_sgn    = (op_i == MD_MULT) || (op_i == MD_DIV);
    assign in_div    = (op_i == MD_DIV) || (op_i == MD_DIVU);
    assign b_zero    = (b_i == 32'd0);
    assign in_mag_a  = mag32(a_i, in_sgn);
    assign in_mag_b  = mag32(b_i, in_sgn);
    assign div_start = accept && in_div && !b_zero;
    assign div_abort = flush_i && (state == ST_DIV);

    div_core #(
        .DIV_ITERS(DIV_ITERS)
    ) u_div (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start    (div_start),
        .dividend (in_mag_a),
        .divisor  (in_mag_b),
        .abort    (div_abort),
        .quotient (quo),
        .remainder(rem),
        .last_iter(last_iter)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (!in_div)     state_nx = ST_MUL;
                    else if (b_zero) state_nx = ST_DONE;
                    else             state_nx = ST_DIV;
                end
            end
            ST_MUL: begin
                if (flush_i)              state_nx = ST_IDLE;
                else if (cnt == MUL_LAST) state_nx = ST_DONE;
            end
            ST_DIV: begin
                if (flush_i)        state_nx = ST_IDLE;
                else if (last_iter) state_nx = ST_DONE;
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (accept)                cnt <= '0;
            else if (state == ST_MUL)  cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            is_mul_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz_q     <= 1'b0;
            a_raw    <= '0;
            mag_a    <= '0;
            mag_b    <= '0;
        end else if (accept) begin
            is_mul_q <= !in_div;
            neg_q    <= in_sgn && (a_i[31] ^ b_i[31]);
            neg_r    <= in_sgn && a_i[31];
            dz_q     <= in_div && b_zero;
            a_raw    <= a_i;
            mag_a    <= in_mag_a;
            mag_b    <= in_mag_b;
        end
    end

    // Free-running product pipeline; operands are stable while in MUL.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < MUL_LATENCY; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= {32'd0, mag_a} * {32'd0, mag_b};
            for (int i = 1; i < MUL_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign prod = pipe[MUL_LATENCY-1];

    always_comb begin
        fin = '0;
        if (dz_q) begin
            fin = {a_raw, DIV_BY_ZERO_LO};
        end else if (is_mul_q) begin
            fin = neg_q ? -prod : prod;
        end else begin
            fin[63:32] = neg_r ? -rem : rem;
            fin[31:0]  = neg_q ? -quo : quo;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            held_hi <= '0;
            held_lo <= '0;
        end else if (state == ST_DONE) begin
            held_hi <= fin[63:32];
            held_lo <= fin[31:0];
        end
    end

    // DONE presents the fresh result; otherwise the last one is held.
    assign done_o  = (state == ST_DONE);
    assign busy_o  = (state != ST_IDLE);
    assign stall_o = accept || (state == ST_MUL) || (state == ST_DIV);
    assign hi_o    = done_o ? fin[63:32] : held_hi;
    assign lo_o    = done_o ? fin[31:0] : held_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: randomized self-checking bench for muldiv_seq against an
// arithmetic reference model; covers latency, flush, reset and corner values.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int ML = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    md_op_e      op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_seq #(
        .MUL_LATENCY(ML),
        .DIV_ITERS  (32)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst_n),
        .start_i(start),
        .op_i   (op),
        .a_i    (a),
        .b_i    (b),
        .flush_i(flush),
        .stall_o(stall_o),
        .busy_o (busy_o),
        .done_o (done_o),
        .hi_o   (hi_o),
        .lo_o   (lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_md(input md_op_e o,
                                           input logic [31:0] x,
                                           input logic [31:0] y);
        longint sx;
        longint sy;
        int     qi;
        int     ri;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (o == MD_MULTU) return {32'd0, x} * {32'd0, y};
        if (o == MD_MULT)  return 64'(sx * sy);
        if (y == 32'd0)    return {x, 32'hFFFF_FFFF};
        if (o == MD_DIVU)  return {x % y, x / y};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
            return {32'd0, 32'h8000_0000};
        qi = $signed(x) / $signed(y);
        ri = $signed(x) % $signed(y);
        return {32'(ri), 32'(qi)};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Starts at a negedge with the DUT idle; ends at a negedge, DUT idle.
    task automatic run_op(input md_op_e o, input logic [31:0] x,
                          input logic [31:0] y, input bit hold,
                          input string tag);
        logic [63:0] e;
        int          exp_lat;
        int          n;
        bit          got;
        bit          stall_ok;
        e = ref_md(o, x, y);
        if (o == MD_MULT || o == MD_MULTU) exp_lat = ML + 1;
        else if (y == 32'd0)               exp_lat = 1;
        else                               exp_lat = 33;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        #1;
        check({tag, " stall0"}, 64'(stall_o), 64'd1);
        @(posedge clk);
        #1;
        start    = hold;
        got      = 1'b0;
        stall_ok = 1'b1;
        n        = 0;
        for (int c = 1; c <= 100; c++) begin
            if (hold) begin
                a = $urandom;
                b = $urandom;
            end
            @(negedge clk);
            if (done_o) begin
                got = 1'b1;
                n   = c;
                break;
            end
            if (!stall_o || !busy_o) stall_ok = 1'b0;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check({tag, " done"}, 64'(got), 64'd1);
        check({tag, " lat"}, 64'(n), 64'(exp_lat));
        check({tag, " stall run"}, 64'(stall_ok), 64'd1);
        check({tag, " result"}, {hi_o, lo_o}, e);
        check({tag, " stall done"}, 64'(stall_o), 64'd0);
        @(negedge clk);
        check({tag, " pulse"}, 64'(done_o), 64'd0);
        check({tag, " idle"}, 64'(busy_o), 64'd0);
        check({tag, " hold"}, {hi_o, lo_o}, e);
    endtask

    initial begin
        bit saw;
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = MD_MULT;
        a     = '0;
        b     = '0;
        #12;
        check("rst busy", 64'(busy_o), 64'd0);
        check("rst stall", 64'(stall_o), 64'd0);
        check("rst done", 64'(done_o), 64'd0);
        check("rst hilo", {hi_o, lo_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(MD_DIVU, 32'd100, 32'd7, 1'b0, "divu100/7");
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, "div-7/2");
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div ovf");
        run_op(MD_DIVU, 32'd5, 32'd0, 1'b0, "divu/0");
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd0, 1'b0, "div/0");
        run_op(MD_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, "mult");
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, "multu");

        // flush during a divide
        start = 1'b1;
        op    = MD_DIV;
        a     = 32'd1234567;
        b     = 32'd89;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush busy", 64'(busy_o), 64'd0);
        check("flush stall", 64'(stall_o), 64'd0);
        saw = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done_o) saw = 1'b1;
            @(negedge clk);
        end
        check("flush nodone", 64'(saw), 64'd0);
        check("flush hold", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFE);
        run_op(MD_DIVU, 32'd9, 32'd3, 1'b0, "divu9/3");

        // flush in IDLE blocks acceptance
        start = 1'b1;
        flush = 1'b1;
        op    = MD_MULTU;
        #1;
        check("idle flush stall", 64'(stall_o), 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("idle flush busy", 64'(busy_o), 64'd0);

        // async reset mid-divide
        start = 1'b1;
        op    = MD_DIV;
        a     = 32'd1000;
        b     = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst busy", 64'(busy_o), 64'd0);
        check("arst stall", 64'(stall_o), 64'd0);
        check("arst done", 64'(done_o), 64'd0);
        check("arst hilo", {hi_o, lo_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(MD_MULTU, 32'd3, 32'd4, 1'b0, "multu3*4");

        for (int i = 0; i < 60; i++) begin
            run_op(md_op_e'($urandom_range(0, 3)), pick(), pick(),
                   ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
